// File: rtl/popcount_pattern_gen_pkg.sv
// -----------------------------------------------------------------------------
// popcount_pattern_gen_pkg
// Shared definitions for the popcount pattern generator:
//   - default width parameters for the generator and its interface
//   - FSM state encoding
//   - helper functions building the first and last pattern of a sequence
// The mask helpers are written against MAX_WIDTH so that any instance width up
// to MAX_WIDTH can use them; callers truncate the result to their own width.
// -----------------------------------------------------------------------------
package popcount_pattern_gen_pkg;

    localparam int DEF_WIDTH = 8;   // data word width
    localparam int DEF_CW    = 4;   // width of the ones-count request field
    localparam int DEF_IDXW  = 8;   // width of the word index output
    localparam int MAX_WIDTH = 64;  // widest word the mask helpers support

    // Generator FSM states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // First word of a k-ones sequence: the k lowest bits set.
    function automatic logic [MAX_WIDTH-1:0] first_mask(input int width, input int k);
        logic [MAX_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            m[i] = (i < k) && (i < width);
        end
        return m;
    endfunction

    // Last word of a k-ones sequence: the k highest bits of a width-bit word set.
    function automatic logic [MAX_WIDTH-1:0] last_mask(input int width, input int k);
        logic [MAX_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            m[i] = (i >= (width - k)) && (i < width);
        end
        return m;
    endfunction

endpackage

// File: rtl/popcount_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// popcount_pattern_gen_if
// Request/response bundle of the pattern generator.
//   req_valid / req_ready / req_count : request channel carrying target k
//   out_valid / out_ready             : output word handshake
//   out_data / out_idx / out_last     : current pattern, its index, end marker
//   err                               : one-cycle pulse for a rejected request
// Modports:
//   slave  - the generator itself
//   master - whoever issues requests and consumes words
// -----------------------------------------------------------------------------
interface popcount_pattern_gen_if
    import popcount_pattern_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = DEF_CW,
    parameter int IDXW  = DEF_IDXW
) ();

    logic             req_valid;
    logic             req_ready;
    logic [CW-1:0]    req_count;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IDXW-1:0]  out_idx;
    logic             out_last;
    logic             err;

    modport slave (
        input  req_valid,
        input  req_count,
        input  out_ready,
        output req_ready,
        output out_valid,
        output out_data,
        output out_idx,
        output out_last,
        output err
    );

    modport master (
        output req_valid,
        output req_count,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last,
        input  err
    );

endinterface

// File: rtl/popcount_pattern_gen_next_combination.sv
// -----------------------------------------------------------------------------
// popcount_pattern_gen_next_combination
// Purely combinational: returns the smallest word greater than i_word that has
// the same number of ones (Gosper's hack, no division).
//   i_word : current pattern
//   o_next : next pattern with identical popcount
// For the numerically last pattern of a given popcount the result overflows and
// is meaningless; the caller never advances past that word.
// -----------------------------------------------------------------------------
module popcount_pattern_gen_next_combination #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_word,
    output logic [WIDTH-1:0] o_next
);

    // Shift amount must reach WIDTH+1 (all-zero input gives ctz = WIDTH)
    localparam int SW = $clog2(WIDTH + 2);

    logic [SW-1:0]    w_ctz;
    logic [SW-1:0]    w_shamt;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_t_inc;
    logic [WIDTH-1:0] w_low_fill;

    // Count trailing zeros: scan from MSB down so the lowest set bit wins
    always_comb begin
        w_ctz = SW'(WIDTH);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            w_ctz = i_word[i] ? SW'(i) : w_ctz;
        end
    end

    // t fills the trailing zeros; t+1 moves the lowest run of ones up by one
    assign w_t     = i_word | (i_word - WIDTH'(1));
    assign w_t_inc = w_t + WIDTH'(1);
    assign w_shamt = w_ctz + SW'(1);

    // Remaining ones of the run are refilled at the bottom. Shifting by a
    // value >= WIDTH yields zero, so the wide shift never drops wanted bits.
    assign w_low_fill = ((~w_t & w_t_inc) - WIDTH'(1)) >> w_shamt;
    assign o_next     = w_t_inc | w_low_fill;

endmodule

// File: rtl/popcount_pattern_gen.sv
// -----------------------------------------------------------------------------
// popcount_pattern_gen
// Given a target ones-count k, emits every WIDTH-bit word with exactly k ones
// in ascending numeric order, one word per out handshake.
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : popcount_pattern_gen_if.slave (request, output words, err pulse)
// Timing:
//   - accepted request -> first word valid the next cycle
//   - k > WIDTH        -> one-cycle err pulse, no output
//   - after the last word's handshake req_ready is low for one bubble cycle
// -----------------------------------------------------------------------------
module popcount_pattern_gen
    import popcount_pattern_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = DEF_CW,
    parameter int IDXW  = DEF_IDXW
) (
    input  logic                    clk,
    input  logic                    rst,
    popcount_pattern_gen_if.slave   bus
);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_req_ready;
    logic             r_err;
    logic [CW-1:0]    r_k;
    logic [WIDTH-1:0] r_data;
    logic [IDXW-1:0]  r_idx;

    logic             w_accept;
    logic             w_k_ok;
    logic             w_load;
    logic             w_adv;
    logic             w_reject;
    logic             w_last;
    logic [WIDTH-1:0] w_first_data;
    logic [WIDTH-1:0] w_last_data;
    logic [WIDTH-1:0] w_next_data;

    // r_req_ready is only ever high in IDLE, so it alone qualifies acceptance
    assign w_accept     = bus.req_valid && r_req_ready;
    assign w_k_ok       = (bus.req_count <= CW'(WIDTH));
    assign w_first_data = WIDTH'(first_mask(WIDTH, int'(bus.req_count)));
    assign w_last_data  = WIDTH'(last_mask(WIDTH, int'(r_k)));
    assign w_last       = (r_data == w_last_data);

    popcount_pattern_gen_next_combination #(
        .WIDTH (WIDTH)
    ) u_next_combination (
        .i_word (r_data),
        .o_next (w_next_data)
    );

    // Next-state and datapath control decode
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_adv        = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_k_ok) begin
                        w_next_state = EMIT;
                        w_load       = 1'b1;
                    end else begin
                        w_reject     = 1'b1;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (w_last) begin
                        w_next_state = IDLE;
                    end else begin
                        w_adv        = 1'b1;
                    end
                end else begin
                    w_next_state = EMIT;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request-side outputs; req_ready computed from the current state gives
    // the single bubble cycle after returning to IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_ready <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            r_req_ready <= (r_state == IDLE) && !w_load;
            r_err       <= w_reject;
        end
    end

    // Pattern datapath: load first word on accept, step on non-final handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k    <= '0;
            r_data <= '0;
            r_idx  <= '0;
        end else if (w_load) begin
            r_k    <= bus.req_count;
            r_data <= w_first_data;
            r_idx  <= '0;
        end else if (w_adv) begin
            r_k    <= r_k;
            r_data <= w_next_data;
            r_idx  <= r_idx + IDXW'(1);
        end else begin
            r_k    <= r_k;
            r_data <= r_data;
            r_idx  <= r_idx;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.out_valid = (r_state == EMIT);
    assign bus.out_data  = r_data;
    assign bus.out_idx   = r_idx;
    // Gated by state so a stale k=0 / data=0 pair reads as not-last in IDLE
    assign bus.out_last  = (r_state == EMIT) && w_last;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_popcount_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_popcount_pattern_gen
// Directed self-checking bench for popcount_pattern_gen (WIDTH=8). A table of
// sequences is replayed against an independent brute-force reference that
// scans ascending integers for the required popcount; hand-written sequences
// cover the rejected request and the asynchronous reset abort.
// -----------------------------------------------------------------------------
module tb_popcount_pattern_gen;

    localparam int WIDTH = 8;
    localparam int CW    = 4;
    localparam int IDXW  = 8;

    typedef struct {
        int         k;
        int         len;
        logic [7:0] first;
        logic [7:0] second;
        logic [7:0] lastw;
        bit         rnd;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    vec_t vecs[9];

    popcount_pattern_gen_if #(.WIDTH(WIDTH), .CW(CW), .IDXW(IDXW)) bus ();

    popcount_pattern_gen #(
        .WIDTH (WIDTH),
        .CW    (CW),
        .IDXW  (IDXW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Smallest 8-bit value with popcount k
    function automatic int ref_first(input int k);
        for (int v = 0; v < 256; v++) begin
            if ($countones(v) == k) return v;
        end
        return -1;
    endfunction

    // Smallest 8-bit value above prev with popcount k, -1 if none
    function automatic int ref_next(input int prev, input int k);
        for (int v = prev + 1; v < 256; v++) begin
            if ($countones(v) == k) return v;
        end
        return -1;
    endfunction

    // Issue one request and consume the whole sequence, checking every cycle
    task automatic run_seq(input int k, input bit rnd, output int n_words,
                           output logic [7:0] first, output logic [7:0] second,
                           output logic [7:0] lastw);
        int         exp_word;
        int         exp_idx;
        int         nxt;
        bit         exp_last;
        bit         done;
        bit         hs;
        n_words = 0;
        first   = 8'h00;
        second  = 8'h00;
        lastw   = 8'h00;
        for (int w = 0; w < 20 && !bus.req_ready; w++) tick();
        check($sformatf("k%0d_req_ready_idle", k), bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_count = CW'(k);
        bus.out_ready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        exp_word = ref_first(k);
        exp_idx  = 0;
        done     = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            nxt      = ref_next(exp_word, k);
            exp_last = (nxt < 0);
            check($sformatf("k%0d_valid", k), bus.out_valid, 1);
            check($sformatf("k%0d_data", k), bus.out_data, exp_word);
            check($sformatf("k%0d_idx", k), bus.out_idx, exp_idx);
            check($sformatf("k%0d_last", k), bus.out_last, exp_last);
            check($sformatf("k%0d_popcount", k), $countones(bus.out_data), k);
            check($sformatf("k%0d_err_low", k), bus.err, 0);
            check($sformatf("k%0d_req_ready_busy", k), bus.req_ready, 0);
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = bus.out_valid && bus.out_ready;
            if (hs) begin
                if (n_words == 0) first = bus.out_data;
                if (n_words == 1) second = bus.out_data;
                lastw = bus.out_data;
                n_words++;
                if (exp_last) begin
                    done = 1'b1;
                end else begin
                    exp_word = nxt;
                    exp_idx++;
                end
            end
            tick();
        end
        if (!done) check($sformatf("k%0d_timeout", k), 0, 1);
        if (n_words == 1) second = first;
        bus.out_ready = 1'b0;
        check($sformatf("k%0d_valid_after_last", k), bus.out_valid, 0);
        check($sformatf("k%0d_bubble_ready", k), bus.req_ready, 0);
        tick();
        check($sformatf("k%0d_ready_return", k), bus.req_ready, 1);
    endtask

    initial begin
        int         n;
        logic [7:0] f;
        logic [7:0] s;
        logic [7:0] l;
        bit         reached;

        n_checks = 0;
        n_errors = 0;
        vecs[0] = '{k: 1, len:  8, first: 8'h01, second: 8'h02, lastw: 8'h80, rnd: 1'b0};
        vecs[1] = '{k: 3, len: 56, first: 8'h07, second: 8'h0B, lastw: 8'hE0, rnd: 1'b0};
        vecs[2] = '{k: 0, len:  1, first: 8'h00, second: 8'h00, lastw: 8'h00, rnd: 1'b0};
        vecs[3] = '{k: 8, len:  1, first: 8'hFF, second: 8'hFF, lastw: 8'hFF, rnd: 1'b0};
        vecs[4] = '{k: 4, len: 70, first: 8'h0F, second: 8'h17, lastw: 8'hF0, rnd: 1'b1};
        vecs[5] = '{k: 2, len: 28, first: 8'h03, second: 8'h05, lastw: 8'hC0, rnd: 1'b1};
        vecs[6] = '{k: 7, len:  8, first: 8'h7F, second: 8'hBF, lastw: 8'hFE, rnd: 1'b0};
        vecs[7] = '{k: 5, len: 56, first: 8'h1F, second: 8'h2F, lastw: 8'hF8, rnd: 1'b0};
        vecs[8] = '{k: 6, len: 28, first: 8'h3F, second: 8'h5F, lastw: 8'hFC, rnd: 1'b1};

        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_count = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_idx", bus.out_idx, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_err", bus.err, 0);
        rst = 1'b1;
        tick();
        check("rst_req_ready", bus.req_ready, 1);

        // Table-driven sequences
        for (int i = 0; i < 9; i++) begin
            run_seq(vecs[i].k, vecs[i].rnd, n, f, s, l);
            check($sformatf("k%0d_len", vecs[i].k), n, vecs[i].len);
            check($sformatf("k%0d_first", vecs[i].k), f, vecs[i].first);
            check($sformatf("k%0d_second", vecs[i].k), s, vecs[i].second);
            check($sformatf("k%0d_lastword", vecs[i].k), l, vecs[i].lastw);
        end

        // Rejected request k=9, then a normal k=2 request
        bus.req_valid = 1'b1;
        bus.req_count = CW'(9);
        tick();
        bus.req_valid = 1'b0;
        check("k9_err_pulse", bus.err, 1);
        check("k9_no_valid", bus.out_valid, 0);
        check("k9_req_ready", bus.req_ready, 1);
        tick();
        check("k9_err_cleared", bus.err, 0);
        check("k9_still_no_valid", bus.out_valid, 0);
        run_seq(2, 1'b0, n, f, s, l);
        check("after_err_first", f, 8'h03);
        check("after_err_len", n, 28);

        // Asynchronous reset in the middle of a k=5 sequence
        bus.req_valid = 1'b1;
        bus.req_count = CW'(5);
        bus.out_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 100 && !reached; c++) begin
            if (bus.out_valid && bus.out_idx == 8'd10) begin
                reached = 1'b1;
            end else begin
                tick();
            end
        end
        check("midrst_reach_idx10", reached, 1);
        rst = 1'b0;
        #2;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_data", bus.out_data, 0);
        check("midrst_out_idx", bus.out_idx, 0);
        check("midrst_out_last", bus.out_last, 0);
        check("midrst_err", bus.err, 0);
        bus.out_ready = 1'b0;
        tick();
        check("midrst_hold_valid", bus.out_valid, 0);
        rst = 1'b1;
        tick();
        run_seq(5, 1'b0, n, f, s, l);
        check("restart_first", f, 8'h1F);
        check("restart_len", n, 56);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
